demux_stream_router: RTL and testbench
======================================

Name: demux_stream_router

Overview:
- Sequential, handshaked successor to the combinational 1-to-4 demux.
- Accepts a data stream tagged with a 2-bit destination select and enable, and routes each accepted word into one of four per-channel FIFOs.
- Each FIFO drains to its own valid/ready consumer.
- Sits between a single producer and four independent downstream channel consumers.

Parameters:
- DATA_W, 8, width of each data word.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer word valid.
- in_ready  out  1  router can accept the current word.
- in_data  in  DATA_W  word to route.
- in_sel  in  2  destination channel, 0..3 (S of the demux).
- in_en  in  1  route enable (En of the demux); 0 means the word is discarded.
- out_valid  out  4  per-channel head-of-FIFO valid.
- out_ready  in  4  per-channel consumer ready.
- out_data  out  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- drop_cnt  out  DROP_CNT_W  number of words discarded because in_en=0.

Behaviour:
- Reset is asynchronous, active-high, on clk.
- Reset values:
  - all FIFOs empty, so out_valid=4'b0000.
  - out_data=0.
  - drop_cnt=0.
  - in_ready follows the combinational rule below; with all FIFOs empty it is 1.
- Reset asserted mid-operation flushes all FIFO contents immediately; no words survive.
- Transfer in: occurs when in_valid && in_ready at a rising edge.
- in_ready rule:
  - in_en=1: in_ready = ~full[in_sel].
  - in_en=0: in_ready = 1.
  - in_ready never depends on out_ready, so there is no combinational ready path through the block.
- Routed write: when in_en=1 and a transfer occurs, in_data is pushed into FIFO[in_sel].
  - Exactly one channel is written.
  - Other channels are untouched, matching one-hot demux semantics.
- Discard: when in_en=0 and a transfer occurs, the word is dropped and drop_cnt increments.
  - drop_cnt saturates at all-ones; it never wraps.
- Latency: a word pushed at edge N is visible on out_valid/out_data of its channel after edge N; the FIFO is not fall-through within the same cycle.
- Transfer out: occurs when out_valid[k] && out_ready[k]. FIFO[k] pops and the next entry, if any, appears the following cycle.
- Ordering: words to the same channel leave in arrival order. There is no ordering relation between channels.
- Simultaneous push and pop on the same channel:
  - Not full: both occur and occupancy is unchanged.
  - Full: the push is refused by in_ready; the pop proceeds.
- Empty channel: out_valid[k]=0 and out_data[k] holds its last value. It is don't-care to the consumer, but must not be X after reset.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is a log2(DEPTH)+1 bit counter per channel: full when count==DEPTH, empty when count==0.
- The producer must hold in_data, in_sel and in_en stable while in_valid=1 and in_ready=0. The bench checks this; the RTL does not.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - Each FIFO entry stores one extra bit: the even parity of in_data.
  - An added output port, out_par (4 bits), gives the stored parity of each channel's head word. It resets to 0.
- Not defined: no parity storage and no out_par port; FIFO entries are DATA_W wide.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH=4.
  - typedef sel_t as a 2-bit logic type.
  - a function returning the one-hot channel decode of a sel_t.
- Sub-module demux_chan_fifo, one per channel via generate:
  - parameters DATA_W, DEPTH.
  - ports clk, rst, push, push_data, pop, full, empty, head_data.
- The top handles select decode, in_ready and drop_cnt.

Test Plan:
- Reset then routing: push 0xA1, 0xB2, 0xC3, 0xD4 with sel=0..3 and en=1, all out_ready=1 -> each channel k shows its word on out_valid[k] one cycle after its push, and nothing appears on the other channels.
- Fill and backpressure: out_ready[2]=0, push 0x11, 0x22, 0x33 to sel=2 with DEPTH=2 -> in_ready=0 on the third word. Raise out_ready[2] -> 0x11 then 0x22 drain, and 0x33 is accepted the cycle after the FIFO leaves full.
- Disable: en=0, sel=2, data=0xFF for 3 words -> in_ready=1, no out_valid rises, drop_cnt=3. Then 300 disabled words with DROP_CNT_W=8 -> drop_cnt holds at 255.
- Simultaneous push/pop at count=1 on channel 1: push 0x55 while popping 0x44 -> count stays 1 and the next head is 0x55.
- Mid-operation reset: with channels 0 and 3 holding data, pulse rst between clock edges -> out_valid=0000 and drop_cnt=0 immediately, with no clock edge needed.
- Parity build with DEMUX_PARITY_EN defined: push 0x07 to sel=1 -> out_par[1]=1. Push 0x03 to sel=1 -> out_par[1]=0 once 0x03 is at the head.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and helpers for the four-channel stream router.
// Channel count, select type and one-hot select decode.
// No logic; no latency or backpressure of its own.
package demux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] sel_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(input sel_t sel);
        sel_onehot = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel synchronous FIFO, DEPTH entries (power of two, >= 2).
// Latency: push at edge N is visible on head_data after edge N; no fall-through.
// Backpressure: push ignored when full, pop ignored when empty; head holds last popped word when empty.
module demux_chan_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] last_q;
    logic              do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Once drained, keep presenting the word that last left rather than a stale slot.
    assign head_data = empty ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_stream_router.sv
// Routes a select-tagged stream into four per-channel FIFOs; en=0 words are dropped and counted.
// Latency: one edge from accept to channel head. Optional head parity via DEMUX_PARITY_EN.
// Backpressure: in_ready = ~full[in_sel] when enabled, else 1; never depends on out_ready.
module demux_stream_router
    import demux_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 2,
    parameter int DROP_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [1:0]                 in_sel,
    input  logic                       in_en,
    output logic [NUM_CH-1:0]          out_valid,
    input  logic [NUM_CH-1:0]          out_ready,
    output logic [NUM_CH*DATA_W-1:0]   out_data,
    output logic [DROP_CNT_W-1:0]      drop_cnt
`ifdef DEMUX_PARITY_EN
    ,
    output logic [NUM_CH-1:0]          out_par
`endif
);

`ifdef DEMUX_PARITY_EN
    localparam int FW = DATA_W + 1;
`else
    localparam int FW = DATA_W;
`endif

    logic [FW-1:0]         push_word;
    logic [FW-1:0]         head_w [NUM_CH];
    logic [NUM_CH-1:0]     full, empty, push, pop, sel_oh;
    logic                  accept;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

`ifdef DEMUX_PARITY_EN
    assign push_word = {^in_data, in_data};
`else
    assign push_word = in_data;
`endif

    assign sel_oh   = sel_onehot(sel_t'(in_sel));
    assign in_ready = in_en ? ~full[in_sel] : 1'b1;
    assign accept   = in_valid & in_ready;
    assign drop_cnt = drop_q;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            assign push[k]      = accept & in_en & sel_oh[k];
            assign pop[k]       = out_ready[k] & ~empty[k];
            assign out_valid[k] = ~empty[k];
            assign out_data[k*DATA_W +: DATA_W] = head_w[k][DATA_W-1:0];
`ifdef DEMUX_PARITY_EN
            assign out_par[k]   = head_w[k][DATA_W];
`endif

            demux_chan_fifo #(
                .DATA_W (FW),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (push[k]),
                .push_data (push_word),
                .pop       (pop[k]),
                .full      (full[k]),
                .empty     (empty[k]),
                .head_data (head_w[k])
            );
        end
    endgenerate

    always_comb begin
        drop_d = drop_q;
        if (accept && !in_en && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_demux_stream_router.sv
// Randomized and directed bench for demux_stream_router against a queue-based channel model.
module tb_demux_stream_router;

    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int DCW   = 8;
    localparam int DMAX  = (1 << DCW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_en;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [4*DW-1:0] out_data;
    logic [DCW-1:0]  drop_cnt;
`ifdef DEMUX_PARITY_EN
    logic [3:0]    out_par;
`endif

    demux_stream_router #(
        .DATA_W     (DW),
        .DEPTH      (DEPTH),
        .DROP_CNT_W (DCW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt)
`ifdef DEMUX_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;
    bit rnd_done = 0;

    logic [DW-1:0] mq [4][$];
    int            m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each channel is a bounded queue, discards count up to saturation.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) mq[k].delete();
            m_drop = 0;
        end else begin
            bit rdy;
            rdy = in_en ? (mq[in_sel].size() < DEPTH) : 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
            end
            if (in_valid && rdy) begin
                if (in_en) mq[in_sel].push_back(in_data);
                else if (m_drop < DMAX) m_drop++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
                if (mq[k].size() != 0) begin
                    chk($sformatf("out_data[%0d]", k), 32'(out_data[k*DW +: DW]), 32'(mq[k][0]));
`ifdef DEMUX_PARITY_EN
                    chk($sformatf("out_par[%0d]", k), 32'(out_par[k]), 32'(^mq[k][0]));
`endif
                end
            end
            chk("in_ready", 32'(in_ready), 32'(in_en ? (mq[in_sel].size() < DEPTH) : 1'b1));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; holds the word stable until accepted.
    task automatic send(input logic [DW-1:0] d, input logic [1:0] s, input logic e);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_en    = e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 for data 0x%0h sel %0d", d, s);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] words [4];
        words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_en = 1'b0;
        out_ready = 4'hF;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_drop_cnt",  32'(drop_cnt),  32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        step();

        // One word per channel, visible only on its own channel.
        for (int k = 0; k < 4; k++) begin
            send(words[k], 2'(k), 1'b1);
            @(negedge clk);
            chk("route_valid", 32'(out_valid), 32'(4'b0001 << k));
            chk("route_data",  32'(out_data[k*DW +: DW]), 32'(words[k]));
            step();
        end

        // Fill channel 2, observe refusal, then drain.
        out_ready = 4'b1011;
        send(8'h11, 2'd2, 1'b1);
        send(8'h22, 2'd2, 1'b1);
        fork
            send(8'h33, 2'd2, 1'b1);
            begin
                @(negedge clk);
                chk("full_in_ready", 32'(in_ready), 32'h0);
                chk("full_head",     32'(out_data[2*DW +: DW]), 32'h11);
                out_ready = 4'hF;
                @(negedge clk);
                chk("drain_head",    32'(out_data[2*DW +: DW]), 32'h22);
                chk("drain_in_ready", 32'(in_ready), 32'h1);
            end
        join
        @(negedge clk);
        chk("late_head", 32'(out_data[2*DW +: DW]), 32'h33);
        step();

        // Discards and saturation.
        for (int i = 0; i < 3; i++) send(8'hFF, 2'd2, 1'b0);
        @(negedge clk);
        chk("drop3",       32'(drop_cnt),  32'd3);
        chk("drop3_valid", 32'(out_valid), 32'h0);
        step();
        for (int i = 0; i < 300; i++) send(8'hFF, 2'd2, 1'b0);
        @(negedge clk);
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        step();

        // Push and pop together at occupancy 1.
        out_ready = 4'b1101;
        send(8'h44, 2'd1, 1'b1);
        out_ready = 4'hF;
        send(8'h55, 2'd1, 1'b1);
        @(negedge clk);
        chk("pp_valid", 32'(out_valid[1]), 32'h1);
        chk("pp_head",  32'(out_data[1*DW +: DW]), 32'h55);
        step();

`ifdef DEMUX_PARITY_EN
        out_ready = 4'b1101;
        send(8'h07, 2'd1, 1'b1);
        @(negedge clk);
        chk("par_07", 32'(out_par[1]), 32'h1);
        step();
        send(8'h03, 2'd1, 1'b1);
        out_ready = 4'hF;
        step();
        @(negedge clk);
        chk("par_03_head", 32'(out_data[1*DW +: DW]), 32'h03);
        chk("par_03",      32'(out_par[1]), 32'h0);
        step();
`endif

        // Asynchronous reset mid-operation.
        out_ready = 4'h0;
        send(8'h5A, 2'd0, 1'b1);
        send(8'hC3, 2'd3, 1'b1);
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'h9);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_drop",  32'(drop_cnt),  32'h0);
        chk("arst_data",  32'(out_data),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Random traffic with random per-channel backpressure.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    send(8'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = 4'($urandom);
                    step();
                end
            end
        join
        out_ready = 4'hF;
        repeat (5) step();
        @(negedge clk);
        chk("final_empty", 32'(out_valid), 32'h0);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
